// File: rtl/ubus_arb_pkg.sv
// Shared types and constants for the UBus central arbiter.
package ubus_arb_pkg;

   typedef enum logic [2:0] {
      ST_RST,
      ST_ARB,
      ST_NOP,
      ST_ADDR,
      ST_DATA
   } ubus_arb_state_e;

   localparam int unsigned UBUS_ARB_FIXED = 0;
   localparam int unsigned UBUS_ARB_RR    = 1;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned owner_width(input int unsigned n);
      return (n <= 2) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/ubus_rr_picker.sv
// Combinational request picker: fixed priority from index 0, or rotating
// priority starting just after the pointer.
module ubus_rr_picker
   import ubus_arb_pkg::*;
#(
   parameter  int unsigned NUM_MASTERS = 2,
   localparam int unsigned OW          = owner_width(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [OW-1:0]          ptr,
   input  logic                   rr_mode,
   output logic [NUM_MASTERS-1:0] gnt_c,
   output logic [OW-1:0]          idx_c,
   output logic                   valid_c
);

   logic [OW-1:0] cand;

   // First asserted request in search order wins.
   always_comb begin
      gnt_c   = '0;
      idx_c   = '0;
      valid_c = 1'b0;
      cand    = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         cand = rr_mode ? OW'((32'(ptr) + 32'd1 + i) % NUM_MASTERS) : OW'(i);
         if (!valid_c && req[cand]) begin
            valid_c     = 1'b1;
            gnt_c[cand] = 1'b1;
            idx_c       = cand;
         end
      end
   end

endmodule

// File: rtl/ubus_arbiter.sv
// UBus central arbiter and phase sequencer: rising edge runs the phase
// sequencer, falling edge registers the grant inside the start cycle.
module ubus_arbiter
   import ubus_arb_pkg::*;
#(
   parameter  int unsigned NUM_MASTERS = 2,
   parameter  int unsigned ARB_MODE    = 0,
   parameter  int unsigned MAX_WAIT    = 16,
   localparam int unsigned OW          = owner_width(NUM_MASTERS)
) (
   input  logic                   ubus_clock,
   input  logic                   ubus_reset,
   input  logic [NUM_MASTERS-1:0] ubus_req,
   output logic [NUM_MASTERS-1:0] ubus_gnt,
   output logic                   ubus_start,
   input  logic                   ubus_bip,
   input  logic                   ubus_wait,
   input  logic                   ubus_error,
   output logic                   ubus_read,
   output logic                   ubus_write,
   output logic                   ubus_timeout,
   output logic [OW-1:0]          ubus_owner
);

   localparam int unsigned WW = owner_width(MAX_WAIT + 1);

   ubus_arb_state_e        state, state_nxt;
   logic                   start_nxt;
   logic                   rw_drive, rw_drive_nxt;
   logic                   timeout_nxt;
   logic [OW-1:0]          owner_nxt;
   logic [OW-1:0]          rr_ptr;
   logic [WW-1:0]          wd_cnt, wd_cnt_nxt;
   logic                   wd_expire;
   logic [NUM_MASTERS-1:0] pick_gnt;
   logic [OW-1:0]          pick_idx;
   logic                   pick_valid;

   ubus_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
      .req     (ubus_req),
      .ptr     (rr_ptr),
      .rr_mode (ARB_MODE == UBUS_ARB_RR),
      .gnt_c   (pick_gnt),
      .idx_c   (pick_idx),
      .valid_c (pick_valid)
   );

   // This cycle's wait would bring the consecutive-wait count up to the limit.
   assign wd_expire = (MAX_WAIT != 0) && ubus_wait &&
                      ((32'(wd_cnt) + 32'd1) == MAX_WAIT);

   always_comb begin
      state_nxt    = state;
      start_nxt    = 1'b0;
      rw_drive_nxt = 1'b0;
      timeout_nxt  = 1'b0;
      owner_nxt    = ubus_owner;
      wd_cnt_nxt   = wd_cnt;
      case (state)
         ST_RST: begin
            state_nxt = ST_ARB;
            start_nxt = 1'b1;
         end
         ST_ARB: begin
            if (|ubus_gnt) begin
               state_nxt = ST_ADDR;
               owner_nxt = rr_ptr;
            end else begin
               state_nxt    = ST_NOP;
               rw_drive_nxt = 1'b1;
            end
         end
         ST_NOP: begin
            state_nxt = ST_ARB;
            start_nxt = 1'b1;
         end
         ST_ADDR: begin
            state_nxt  = ST_DATA;
            wd_cnt_nxt = '0;
         end
         ST_DATA: begin
            wd_cnt_nxt = ubus_wait ? wd_cnt + WW'(1) : '0;
            // Error outranks watchdog expiry and suppresses the timeout pulse.
            if (ubus_error || (!ubus_bip && !ubus_wait) || wd_expire) begin
               state_nxt   = ST_ARB;
               start_nxt   = 1'b1;
               timeout_nxt = wd_expire && !ubus_error;
            end
         end
         default: state_nxt = ST_RST;
      endcase
   end

   always_ff @(posedge ubus_clock or posedge ubus_reset) begin
      if (ubus_reset) begin
         state        <= ST_RST;
         ubus_start   <= 1'b0;
         rw_drive     <= 1'b0;
         ubus_timeout <= 1'b0;
         ubus_owner   <= '0;
         wd_cnt       <= '0;
      end else begin
         state        <= state_nxt;
         ubus_start   <= start_nxt;
         rw_drive     <= rw_drive_nxt;
         ubus_timeout <= timeout_nxt;
         ubus_owner   <= owner_nxt;
         wd_cnt       <= wd_cnt_nxt;
      end
   end

   // Grant register; the pointer records the last winner in either mode.
   always_ff @(negedge ubus_clock or posedge ubus_reset) begin
      if (ubus_reset) begin
         ubus_gnt <= '0;
         rr_ptr   <= OW'(NUM_MASTERS - 1);
      end else if (ubus_start && pick_valid) begin
         ubus_gnt <= pick_gnt;
         rr_ptr   <= pick_idx;
      end else begin
         ubus_gnt <= '0;
      end
   end

   assign ubus_read  = rw_drive ? 1'b0 : 1'bz;
   assign ubus_write = rw_drive ? 1'b0 : 1'bz;

endmodule
